// File: rtl/layer_sequencer.sv
// Forward-pass controller for an N-layer cached dilated causal conv stack.
// It sequences the input shift, each conv core, and each activation cache, and keeps overrun, fault and latency statistics.
module layer_sequencer #(
   parameter int N_LAYERS = 4,
   parameter int W        = 16,
   parameter int CH       = 4,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 1024
) (
   input  logic                                      sample_clk,
   input  logic                                      rst,
   input  logic                                      in_valid,
   input  logic [CH*W-1:0]                           in_sample,
   output logic                                      in_ready,
   output logic                                      shift_in,
   output logic [CH*W-1:0]                           shift_data,
   output logic [N_LAYERS-1:0]                       layer_start,
   input  logic [N_LAYERS-1:0]                       layer_done,
   output logic [(N_LAYERS > 1 ? N_LAYERS-2 : 0):0]  cache_shift,
   input  logic [CH*W-1:0]                           final_out,
   output logic [CH*W-1:0]                           out_sample,
   output logic                                      out_valid,
   output logic                                      busy,
   output logic                                      overrun,
   output logic                                      fault,
   output logic [CNT_W-1:0]                          drop_count,
   output logic [CNT_W-1:0]                          last_latency,
   output logic [CNT_W-1:0]                          max_latency,
   input  logic                                      clear_stats
);

   localparam int KW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_SHIFT, S_START, S_WAIT, S_CACHE, S_OUTPUT, S_ABORT
   } state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [TW-1:0]     wait_q, wait_d;
   logic [CNT_W-1:0]  lat_q, lat_d, lat_inc;
   logic [CH*W-1:0]   shift_data_q, shift_data_d;
   logic [CH*W-1:0]   out_sample_q, out_sample_d;
   logic              out_valid_q, out_valid_d;
   logic              overrun_q, overrun_d;
   logic              fault_q, fault_d;
   logic [CNT_W-1:0]  drop_q, drop_d;
   logic [CNT_W-1:0]  last_q, last_d;
   logic [CNT_W-1:0]  max_q, max_d;

   // NOTE: every signal gets its default before the case so that no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      k_d          = k_q;
      wait_d       = wait_q;
      lat_d        = lat_q;
      shift_data_d = shift_data_q;
      out_sample_d = out_sample_q;
      out_valid_d  = 1'b0;
      overrun_d    = overrun_q;
      fault_d      = fault_q;
      drop_d       = drop_q;
      last_d       = last_q;
      max_d        = max_q;

      // The latency counter reads as the number of cycles elapsed since the accept edge.
      lat_inc = (lat_q == CNT_MAX) ? lat_q : lat_q + 1'b1;
      if (state_q != S_IDLE) lat_d = lat_inc;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_data_d = in_sample;
               lat_d        = CNT_W'(1);
               k_d          = '0;
               state_d      = S_SHIFT;
            end
         end
         S_SHIFT: state_d = S_START;
         S_START: begin
            wait_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (layer_done[k_q]) begin
               state_d = (k_q == KW'(N_LAYERS - 1)) ? S_OUTPUT : S_CACHE;
            end else if (wait_q == TW'(TIMEOUT - 1)) begin
               state_d = S_ABORT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_CACHE: begin
            k_d     = k_q + 1'b1;
            state_d = S_START;
         end
         S_OUTPUT: begin
            out_sample_d = final_out;
            out_valid_d  = 1'b1;
            last_d       = lat_inc;
            if (lat_inc > max_q) max_d = lat_inc;
            state_d      = S_IDLE;
         end
         S_ABORT: begin
            fault_d = 1'b1;
            k_d     = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (in_valid && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
         if (drop_q != CNT_MAX) drop_d = drop_q + 1'b1;
      end

      // Clearing wins over any set or increment in the same cycle.
      if (clear_stats) begin
         overrun_d = 1'b0;
         fault_d   = 1'b0;
         drop_d    = '0;
         max_d     = '0;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the values from before the edge.
   always_ff @(posedge sample_clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         k_q          <= '0;
         wait_q       <= '0;
         lat_q        <= '0;
         shift_data_q <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         fault_q      <= 1'b0;
         drop_q       <= '0;
         last_q       <= '0;
         max_q        <= '0;
      end else begin
         state_q      <= state_d;
         k_q          <= k_d;
         wait_q       <= wait_d;
         lat_q        <= lat_d;
         shift_data_q <= shift_data_d;
         out_sample_q <= out_sample_d;
         out_valid_q  <= out_valid_d;
         overrun_q    <= overrun_d;
         fault_q      <= fault_d;
         drop_q       <= drop_d;
         last_q       <= last_d;
         max_q        <= max_d;
      end
   end

   always_comb begin
      layer_start = '0;
      cache_shift = '0;
      if (state_q == S_START) layer_start[k_q] = 1'b1;
      // With a single layer there is no activation cache, so the lone cache_shift bit is tied low.
      if ((state_q == S_CACHE) && (N_LAYERS > 1)) cache_shift[k_q] = 1'b1;
   end

   assign in_ready     = (state_q == S_IDLE);
   assign busy         = (state_q != S_IDLE);
   assign shift_in     = (state_q == S_SHIFT);
   assign shift_data   = shift_data_q;
   assign out_sample   = out_sample_q;
   assign out_valid    = out_valid_q;
   assign overrun      = overrun_q;
   assign fault        = fault_q;
   assign drop_count   = drop_q;
   assign last_latency = last_q;
   assign max_latency  = max_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: stub conv cores answer D cycles after their start pulse.
// Strobe timing, drops, timeout abort, reset abort and statistics clearing are each exercised.
module tb_layer_sequencer;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int CH = 4;
   localparam int CW = 16;
   localparam int TO = 16;
   localparam int D  = 5;

   logic                sample_clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic [CH*W-1:0]     in_sample;
   logic                in_ready;
   logic                shift_in;
   logic [CH*W-1:0]     shift_data;
   logic [N-1:0]        layer_start;
   logic [N-1:0]        layer_done;
   logic [N-2:0]        cache_shift;
   logic [CH*W-1:0]     final_out;
   logic [CH*W-1:0]     out_sample;
   logic                out_valid;
   logic                busy;
   logic                overrun;
   logic                fault;
   logic [CW-1:0]       drop_count;
   logic [CW-1:0]       last_latency;
   logic [CW-1:0]       max_latency;
   logic                clear_stats;

   layer_sequencer #(.N_LAYERS(N), .W(W), .CH(CH), .CNT_W(CW), .TIMEOUT(TO)) dut (
      .sample_clk(sample_clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
      .in_ready(in_ready), .shift_in(shift_in), .shift_data(shift_data),
      .layer_start(layer_start), .layer_done(layer_done), .cache_shift(cache_shift),
      .final_out(final_out), .out_sample(out_sample), .out_valid(out_valid),
      .busy(busy), .overrun(overrun), .fault(fault), .drop_count(drop_count),
      .last_latency(last_latency), .max_latency(max_latency), .clear_stats(clear_stats)
   );

   always #5 sample_clk = ~sample_clk;

   // Stub cores: done rises D cycles after the start cycle and holds until the next start.
   logic [3:0] core_cnt [N];
   logic [N-1:0] kill;
   always @(posedge sample_clk or posedge rst) begin
      for (int k = 0; k < N; k++) begin
         if (rst) core_cnt[k] <= '0;
         else if (layer_start[k]) core_cnt[k] <= 4'd1;
         else if (core_cnt[k] != 0 && core_cnt[k] < D) core_cnt[k] <= core_cnt[k] + 4'd1;
      end
   end
   always_comb begin
      layer_done = '0;
      for (int k = 0; k < N; k++) layer_done[k] = (core_cnt[k] >= D) && !kill[k];
   end

   int cyc = 0;
   always @(posedge sample_clk) cyc <= cyc + 1;

   int sh_at, ov_at, ov_cnt = 0;
   int ls_at [N];
   int cs_at [N-1];
   always @(posedge sample_clk) begin
      #1;
      if (shift_in) sh_at = cyc;
      for (int k = 0; k < N; k++) if (layer_start[k]) ls_at[k] = cyc;
      for (int k = 0; k < N-1; k++) if (cache_shift[k]) cs_at[k] = cyc;
      if (out_valid) begin
         ov_at = cyc;
         ov_cnt++;
      end
   end

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called on a falling edge; the in_valid pulse covers exactly one rising edge.
   task automatic send(input logic [CH*W-1:0] s, output int t);
      in_sample = s;
      in_valid  = 1'b1;
      t         = cyc;
      @(negedge sample_clk);
      in_valid  = 1'b0;
   endtask

   task automatic wait_until(input int abs_cyc);
      while (cyc < abs_cyc) @(negedge sample_clk);
   endtask

   task automatic wait_out(input int n_before, input string tag);
      int i = 0;
      while (ov_cnt == n_before && i < 200) begin
         @(negedge sample_clk);
         i++;
      end
      check(tag, 64'(ov_cnt - n_before), 64'd1);
   endtask

   initial begin
      int t0, t1, tx, n;
      logic [CH*W-1:0] prev;
      rst = 1'b1; in_valid = 1'b0; in_sample = '0; final_out = '0;
      clear_stats = 1'b0; kill = '0;
      repeat (2) @(negedge sample_clk);
      rst = 1'b0;
      @(negedge sample_clk);

      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_sample", 64'(out_sample), 64'd0);
      check("rst_stats", {overrun, fault, drop_count, max_latency, last_latency}, 64'd0);

      // Single pass: strobe timing of every stage.
      final_out = 64'h1111_2222_3333_4444;
      n = ov_cnt;
      send(64'hA5A5_0001_0002_0003, t0);
      wait_out(n, "t1_done");
      check("t1_shift_at", 64'(sh_at - t0), 64'd1);
      for (int k = 0; k < N; k++) check($sformatf("t1_start%0d_at", k), 64'(ls_at[k] - t0), 64'(2 + 7*k));
      for (int k = 0; k < N-1; k++) check($sformatf("t1_cache%0d_at", k), 64'(cs_at[k] - t0), 64'(8 + 7*k));
      check("t1_out_at", 64'(ov_at - t0), 64'd30);
      check("t1_last_lat", 64'(last_latency), 64'd30);
      check("t1_out_sample", 64'(out_sample), 64'h1111_2222_3333_4444);
      check("t1_shift_data", 64'(shift_data), 64'hA5A5_0001_0002_0003);

      // Ten back-to-back passes, one every 31 cycles.
      for (int i = 0; i < 10; i++) begin
         @(negedge sample_clk);
         final_out = 64'(i * 3 + 7);
         n = ov_cnt;
         send(64'(i), t0);
         wait_out(n, $sformatf("t2_done%0d", i));
         check($sformatf("t2_out_at%0d", i), 64'(ov_at - t0), 64'd30);
      end
      check("t2_overrun", 64'(overrun), 64'd0);
      check("t2_drops", 64'(drop_count), 64'd0);
      check("t2_max_lat", 64'(max_latency), 64'd30);
      check("t2_out_sample", 64'(out_sample), 64'd34);

      // Sample at cycle 12 is dropped; one at the out_valid cycle is accepted.
      @(negedge sample_clk);
      n = ov_cnt;
      send(64'h10, t0);
      wait_until(t0 + 12);
      send(64'h11, tx);
      wait_out(n, "t3_done");
      check("t3_out_at", 64'(ov_at - t0), 64'd30);
      check("t3_overrun", 64'(overrun), 64'd1);
      check("t3_drops", 64'(drop_count), 64'd1);
      check("t3_shift_data", 64'(shift_data), 64'h10);
      n = ov_cnt;
      send(64'h12, t1);
      check("t3_accept_at_out", 64'(t1 - t0), 64'd30);
      wait_out(n, "t3_third_done");
      check("t3_third_out_at", 64'(ov_at - t1), 64'd30);
      check("t3_drops_after", 64'(drop_count), 64'd1);

      // Two more drops, then clear the statistics.
      @(negedge sample_clk);
      n = ov_cnt;
      send(64'h20, t0);
      wait_until(t0 + 5);
      send(64'h21, tx);
      wait_until(t0 + 10);
      send(64'h22, tx);
      wait_out(n, "t6_done");
      check("t6_drops", 64'(drop_count), 64'd3);
      check("t6_overrun", 64'(overrun), 64'd1);
      check("t6_max_lat", 64'(max_latency), 64'd30);
      @(negedge sample_clk);
      clear_stats = 1'b1;
      @(negedge sample_clk);
      clear_stats = 1'b0;
      check("t6_clr_overrun", 64'(overrun), 64'd0);
      check("t6_clr_drops", 64'(drop_count), 64'd0);
      check("t6_clr_max", 64'(max_latency), 64'd0);
      check("t6_keep_last", 64'(last_latency), 64'd30);

      // Core 2 never answers: timeout abort.
      prev = out_sample;
      kill = 4'b0100;
      final_out = 64'hDEAD_BEEF_0000_0001;
      @(negedge sample_clk);
      n = ov_cnt;
      send(64'h30, t0);
      wait_until(t0 + 60);
      check("t4_fault", 64'(fault), 64'd1);
      check("t4_no_out", 64'(ov_cnt - n), 64'd0);
      check("t4_out_held", 64'(out_sample), 64'(prev));
      check("t4_idle", 64'(in_ready), 64'd1);
      kill = '0;
      n = ov_cnt;
      send(64'h31, t0);
      wait_out(n, "t4_recover_done");
      check("t4_recover_lat", 64'(last_latency), 64'd30);
      check("t4_recover_out", 64'(out_sample), 64'hDEAD_BEEF_0000_0001);

      // Reset in the middle of a pass.
      @(negedge sample_clk);
      n = ov_cnt;
      send(64'h40, t0);
      wait_until(t0 + 10);
      check("t5_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_strobes", {shift_in, out_valid, layer_start, cache_shift}, 64'd0);
      check("t5_out_sample", 64'(out_sample), 64'd0);
      check("t5_stats", {fault, last_latency, drop_count}, 64'd0);
      @(negedge sample_clk);
      rst = 1'b0;
      repeat (40) @(negedge sample_clk);
      check("t5_no_out", 64'(ov_cnt - n), 64'd0);
      n = ov_cnt;
      send(64'h41, t0);
      wait_out(n, "t5_post_done");
      check("t5_post_lat", 64'(last_latency), 64'd30);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
